// File: rtl/nios2_system_led_pwm_if.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_system_led_pwm_if
//  Description : Avalon-MM slave bus bundle for the LED PWM stage
//                (4-word register window, zero-wait writes, combinational
//                reads).
//  Revision    : 1.0 - initial release
// ============================================================================
interface nios2_system_led_pwm_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/nios2_system_led_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_system_led_pwm
//  Description : LED driver stage behind the LEDs PIO. Applies a global PWM
//                brightness and optional blink to the 8-bit pattern, or
//                forwards it registered in bypass mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios2_system_led_pwm #(
    parameter int PRESCALE   = 196,
    parameter int PRESCALE_W = 8
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    nios2_system_led_pwm_if.slave   avs,
    input  wire logic [7:0]         led_in,
    output logic      [7:0]         led_out
);

    localparam logic [PRESCALE_W-1:0] c_presc_max = PRESCALE_W'(PRESCALE - 1);
    localparam logic [1:0] c_addr_ctrl   = 2'd0;
    localparam logic [1:0] c_addr_duty   = 2'd1;
    localparam logic [1:0] c_addr_bdiv   = 2'd2;
    localparam logic [1:0] c_addr_status = 2'd3;

    // Software-visible registers
    logic [1:0]            r_ctrl;        // [0] EN, [1] BLINK
    logic [7:0]            r_duty;
    logic [15:0]           r_blink_div;

    // Timing and sampled state
    logic [PRESCALE_W-1:0] r_presc;
    logic [7:0]            r_pwm_cnt;
    logic [7:0]            r_duty_act;
    logic [7:0]            r_led_q;
    logic [15:0]           r_blink_cnt;
    logic                  r_phase;

    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_duty;
    logic                  w_wr_bdiv;
    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_pwm_on;
    logic                  w_gate;
    logic                  w_unused;

    assign w_wr      = avs.chipselect && !avs.write_n;
    assign w_wr_ctrl = w_wr && (avs.address == c_addr_ctrl);
    assign w_wr_duty = w_wr && (avs.address == c_addr_duty);
    assign w_wr_bdiv = w_wr && (avs.address == c_addr_bdiv);

    assign w_tick    = (r_presc == c_presc_max);
    assign w_wrap    = w_tick && (r_pwm_cnt == 8'hFF);
    assign w_pwm_on  = (r_pwm_cnt < r_duty_act);
    assign w_gate    = w_pwm_on && (!r_ctrl[1] || r_phase);

    // Upper write-data bits have no register behind them
    assign w_unused  = &{1'b0, avs.writedata[31:16]};

    // Register file writes; STATUS (addr3) writes fall through and are ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl      <= 2'b00;
            r_duty      <= 8'hFF;
            r_blink_div <= 16'h0000;
        end else begin
            if (w_wr_ctrl) r_ctrl      <= avs.writedata[1:0];
            if (w_wr_duty) r_duty      <= avs.writedata[7:0];
            if (w_wr_bdiv) r_blink_div <= avs.writedata[15:0];
        end
    end

    // Prescaler and free-running PWM counter; never stopped by EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= 8'h00;
        end else begin
            if (w_tick) begin
                r_presc   <= '0;
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end else begin
                r_presc   <= r_presc + 1'b1;
            end
        end
    end

    // Pattern and duty are latched only at the period boundary so a period is
    // never torn; a DUTY write landing on the wrap takes effect immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_led_q    <= 8'h00;
            r_duty_act <= 8'hFF;
        end else if (w_wrap) begin
            r_led_q    <= led_in;
            r_duty_act <= w_wr_duty ? avs.writedata[7:0] : r_duty;
        end
    end

    // Blink divider; reprogramming restarts it in the lit phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt <= 16'h0000;
            r_phase     <= 1'b1;
        end else if (w_wr_bdiv) begin
            r_blink_cnt <= 16'h0000;
            r_phase     <= 1'b1;
        end else if (w_wrap) begin
            if (r_blink_cnt == r_blink_div) begin
                r_blink_cnt <= 16'h0000;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 16'd1;
            end
        end
    end

    // LED pin drive: straight bypass when disabled, gated pattern otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= 8'h00;
        end else if (r_ctrl[0]) begin
            led_out <= r_led_q & {8{w_gate}};
        end else begin
            led_out <= led_in;
        end
    end

    // Zero-latency read mux
    always_comb begin
        avs.readdata = 32'h0000_0000;
        case (avs.address)
            c_addr_ctrl:   avs.readdata = {30'd0, r_ctrl};
            c_addr_duty:   avs.readdata = {24'd0, r_duty};
            c_addr_bdiv:   avs.readdata = {16'd0, r_blink_div};
            c_addr_status: avs.readdata = {16'd0, r_pwm_cnt, 7'd0, r_phase};
            default:       avs.readdata = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_nios2_system_led_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios2_system_led_pwm
//  Description : Self-checking bench for nios2_system_led_pwm. A reference
//                model pushes the expected led_out for every clock edge into
//                a queue; the checker pops and compares just after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_nios2_system_led_pwm;

    localparam int PRESCALE = 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] led_in;
    logic [7:0] led_out;

    nios2_system_led_pwm_if bus ();

    nios2_system_led_pwm #(
        .PRESCALE   (PRESCALE),
        .PRESCALE_W (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (bus),
        .led_in  (led_in),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [1:0]  m_ctrl;
    logic [7:0]  m_duty;
    logic [15:0] m_div;
    logic [7:0]  m_pwm;
    logic [7:0]  m_duty_act;
    logic [7:0]  m_led_q;
    logic [15:0] m_bcnt;
    logic        m_phase;
    int          m_presc;
    logic [7:0]  exp_q[$];

    logic m_wr, m_tick, m_wrap;
    assign m_wr   = bus.chipselect && !bus.write_n;
    assign m_tick = (m_presc == PRESCALE - 1);
    assign m_wrap = m_tick && (m_pwm == 8'hFF);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ctrl     <= 2'b00;
            m_duty     <= 8'hFF;
            m_div      <= 16'h0;
            m_pwm      <= 8'h00;
            m_duty_act <= 8'hFF;
            m_led_q    <= 8'h00;
            m_bcnt     <= 16'h0;
            m_phase    <= 1'b1;
            m_presc    <= 0;
            exp_q.delete();
        end else begin
            exp_q.push_back(m_ctrl[0]
                ? (m_led_q & {8{(m_pwm < m_duty_act) && (!m_ctrl[1] || m_phase)}})
                : led_in);
            m_presc <= m_tick ? 0 : m_presc + 1;
            if (m_tick) m_pwm <= m_pwm + 8'd1;
            if (m_wrap) begin
                m_led_q    <= led_in;
                m_duty_act <= (m_wr && bus.address == 2'd1) ? bus.writedata[7:0] : m_duty;
            end
            if (m_wr && bus.address == 2'd0) m_ctrl <= bus.writedata[1:0];
            if (m_wr && bus.address == 2'd1) m_duty <= bus.writedata[7:0];
            if (m_wr && bus.address == 2'd2) begin
                m_div   <= bus.writedata[15:0];
                m_bcnt  <= 16'h0;
                m_phase <= 1'b1;
            end else if (m_wrap) begin
                if (m_bcnt == m_div) begin
                    m_bcnt  <= 16'h0;
                    m_phase <= ~m_phase;
                end else begin
                    m_bcnt  <= m_bcnt + 16'd1;
                end
            end
        end
    end

    // Scoreboard consumer: one expected led_out per edge
    always @(posedge clk) begin
        #1;
        if (reset_n && exp_q.size() > 0) check_eq("led_out", {24'd0, led_out}, {24'd0, exp_q.pop_front()});
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // Called while clk is low; samples 1 ns after setting the address
    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic wait_pwm(input logic [7:0] v, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_pwm == v) found = 1'b1;
        end
        if (!found) check_eq(tag, 32'd0, 32'd1);
    endtask

    task automatic count_high(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (led_out == 8'hFF) n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] rd;
        int          n;

        reset_n        = 1'b0;
        led_in         = 8'h00;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset mid-run with an active output
        led_in = 8'hFF;
        bus_write(2'd0, 32'h1);
        repeat (300) @(negedge clk);
        check_eq("pre_reset_active", {24'd0, led_out}, 32'h0000_00FF);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("reset_async_led", {24'd0, led_out}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd0, rd); check_eq("reset_ctrl", rd, 32'h0);
        bus_read(2'd1, rd); check_eq("reset_duty", rd, 32'hFF);
        bus_read(2'd2, rd); check_eq("reset_bdiv", rd, 32'h0);
        bus_read(2'd3, rd); check_eq("reset_status", rd, 32'h1);

        // Bypass
        @(negedge clk); led_in = 8'hA5;
        @(posedge clk); #1; check_eq("bypass_a5", {24'd0, led_out}, 32'hA5);
        @(negedge clk); led_in = 8'h3C;
        @(posedge clk); #1; check_eq("bypass_3c", {24'd0, led_out}, 32'h3C);

        // PWM duty
        @(negedge clk); led_in = 8'hFF;
        bus_write(2'd0, 32'h1);
        bus_write(2'd1, 32'd64);
        wait_pwm(8'd0, "wrap_timeout_d64");
        count_high(256, n); check_eq("duty64_high", n, 64);
        bus_write(2'd1, 32'd0);
        wait_pwm(8'd0, "wrap_timeout_d0");
        count_high(256, n); check_eq("duty0_high", n, 0);
        bus_write(2'd1, 32'd255);
        wait_pwm(8'd0, "wrap_timeout_d255");
        count_high(256, n); check_eq("duty255_high", n, 255);

        // Mid-period sampling
        @(negedge clk); led_in = 8'h0F;
        wait_pwm(8'd0, "wrap_timeout_mid0");
        wait_pwm(8'd100, "pwm100_timeout");
        @(negedge clk); led_in = 8'hF0;
        @(posedge clk); #1; check_eq("mid_hold_0f", {24'd0, led_out}, 32'h0F);
        wait_pwm(8'd0, "wrap_timeout_mid1");
        @(posedge clk); #1; check_eq("next_period_f0", {24'd0, led_out}, 32'hF0);

        // DUTY write on the exact wrap cycle
        @(negedge clk); led_in = 8'hFF;
        wait_pwm(8'd255, "pwm255_timeout");
        bus_write(2'd1, 32'h10);
        count_high(256, n); check_eq("duty_at_wrap_high", n, 16);

        // Blink: two lit periods, two dark
        bus_write(2'd1, 32'd255);
        bus_write(2'd0, 32'h3);
        bus_write(2'd2, 32'h1);
        wait_pwm(8'd0, "wrap_timeout_blink");
        count_high(1024, n); check_eq("blink_4period_high", n, 510);
        begin
            bit dark = 1'b0;
            for (int i = 0; i < 1200 && !dark; i++) begin
                @(posedge clk); #1;
                if (!m_phase) dark = 1'b1;
            end
            check_eq("blink_dark_seen", {31'd0, dark}, 32'd1);
        end
        bus_write(2'd2, 32'h1);
        bus_read(2'd3, rd); check_eq("bdiv_forces_phase", {31'd0, rd[0]}, 32'd1);

        // Writes to STATUS change nothing
        bus_write(2'd1, 32'h10);
        @(negedge clk);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd0, rd); check_eq("addr3_ctrl", rd, 32'h3);
        bus_read(2'd1, rd); check_eq("addr3_duty", rd, 32'h10);
        bus_read(2'd2, rd); check_eq("addr3_bdiv", rd, 32'h1);

        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
